alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU bitwise/arith function units (NOR, AND, OR, XOR, ADD). It takes the selected 16-bit unit result and derives N/Z/C/V flags.
- Buffers result and flags in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Maintains the architectural status register consumed by the MCU branch logic.

Parameters:
- WIDTH, 16, result datapath width in bits
- TAG_W, 3, destination-register tag width

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  upstream result valid
- IN_READY  output  1  stage can accept a result this cycle
- IN_RES  input  WIDTH  result from selected function unit
- IN_C  input  1  carry from unit (0 for logic ops)
- IN_V  input  1  overflow from unit (0 for logic ops)
- IN_TAG  input  TAG_W  destination register tag
- IN_FLAG_EN  input  1  result updates STATUS when retired
- FLUSH  input  1  synchronous discard of buffered results
- OUT_VALID  output  1  head entry valid
- OUT_READY  input  1  writeback accepts head entry
- OUT_RES  output  WIDTH  head result
- OUT_TAG  output  TAG_W  head tag
- OUT_FLAGS  output  4  head flags {N,Z,C,V}
- STATUS  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset (RST_N=0, async): FIFO count=0, pointers=0, OUT_VALID=0, OUT_RES=0, OUT_TAG=0, OUT_FLAGS=0, STATUS=0, IN_READY=1 after release.
- Flag derivation at push time:
  - N = IN_RES[WIDTH-1]
  - Z = (IN_RES == 0)
  - C = IN_C, V = IN_V
  - Stored with the entry together with IN_TAG and IN_FLAG_EN.
- Push: IN_VALID & IN_READY at a rising edge.
- Pop: OUT_VALID & OUT_READY at a rising edge.
- IN_READY = (count < 2). It is registered-state derived only, with no combinational path from OUT_READY.
- Latency: result pushed at edge k appears on OUT_* with OUT_VALID=1 after edge k (1 cycle), in FIFO order.
- OUT_* reflect the head entry. When count=0, OUT_RES/OUT_TAG/OUT_FLAGS hold their last values and OUT_VALID=0.
- count transitions:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged (legal only at count=1; at count=2 there is no push)
- Full (count=2): IN_READY=0. IN_VALID is ignored and upstream must hold its data.
- Empty (count=0) with OUT_READY=1: no pop, no state change.
- Pointers are 1 bit and wrap modulo 2.
- STATUS: on a pop whose entry has flag_en=1, STATUS <= that entry's flags at the same edge. Entries with flag_en=0 leave STATUS unchanged.
- FLUSH=1 at an edge:
  - count <= 0, pointers <= 0, OUT_VALID <= 0.
  - A push or pop in the same cycle is discarded and does not update STATUS.
  - STATUS itself is retained.
  - IN_READY=1 in the following cycle.
- Reset mid-operation: all buffered entries are lost immediately (async), and outputs take their reset values.
- Upstream contract: IN_* are stable while IN_VALID=1 and IN_READY=0. A violation is a bench error.

Decomposition:
- Package alu_pkg holds:
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - a flag struct/typedef (4 bits)
  - the entry layout {res, tag, flags, flag_en}
- Sub-module alu_skid_fifo: generic 2-entry FIFO, parameterised on entry width, owning count/pointers/valid/ready.
- alu_result_stage itself does flag derivation, entry packing, STATUS and FLUSH gating.

Test Plan:
- Push IN_RES=16'h0000, IN_C=0, IN_V=0, IN_FLAG_EN=1, tag 3, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_FLAGS=4'b0100, OUT_TAG=3. After pop, STATUS=4'b0100.
- Push 16'h8001 with IN_C=1, IN_V=1, flag_en=0, and pop -> OUT_FLAGS=4'b1011, STATUS unchanged from its prior value.
- OUT_READY=0, push 16'h0011 then 16'h0022 -> IN_READY=0 after the second push and a third input is held. Raise OUT_READY -> outputs 16'h0011 then 16'h0022 then the held third value, no loss or duplication.
- count=1 with simultaneous push 16'h00AA and pop -> count stays 1, the head advances to 16'h00AA next cycle, continuous streaming at 1 result/cycle.
- Two entries buffered, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, STATUS unchanged, the flushed-cycle input is absent from the output.
- Drop RST_N asynchronously mid-stream with 2 entries buffered -> outputs 0 immediately without waiting for a clock edge, STATUS=0, OUT_VALID=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions, flag
// record, entry layout and a helper that sizes a packed entry.
// Entry layout (MSB..LSB): {res, tag, flags[3:0], flag_en}.
package alu_pkg;

    // Bit positions inside a 4-bit {N,Z,C,V} flag vector.
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;
    localparam int FLAGS_W = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Entry layout at the default datapath widths; parameterised instances
    // use the same field order, sliced with entry_w() offsets.
    localparam int RES_W_DEF = 16;
    localparam int TAG_W_DEF = 3;

    typedef struct packed {
        logic [RES_W_DEF-1:0] res;
        logic [TAG_W_DEF-1:0] tag;
        flags_t               flags;
        logic                 flag_en;
    } entry_t;

    function automatic int entry_w(input int res_w, input int tag_w);
        return res_w + tag_w + FLAGS_W + 1;
    endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Generic 2-entry FIFO with registered head output and valid/ready on both sides.
// Latency: an entry pushed at edge k is presented on out_dat/out_valid after edge k.
// Backpressure: in_ready = (count < 2), from registered state only; flush empties it.
//
// Ports: clk, rst_n (async active-low), flush (sync discard), in_valid/in_ready/in_dat
// (push side), out_valid/out_ready/out_dat (pop side; out_dat holds when empty).
module alu_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_dat
);

    logic [DW-1:0] mem [2];
    logic [DW-1:0] head_q;
    logic [DW-1:0] head_n;
    logic [1:0]    count;
    logic [1:0]    count_n;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          rd_ptr_n;
    logic          push;
    logic          pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_dat   = head_q;

    always_comb begin
        push     = in_valid & in_ready & ~flush;
        pop      = out_valid & out_ready & ~flush;
        rd_ptr_n = rd_ptr ^ pop;
        count_n  = count + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_n  = 2'd0;
            rd_ptr_n = 1'b0;
        end
        // Head register follows the next head entry; when the FIFO goes
        // empty it keeps the last value shown. The slot being written this
        // cycle is bypassed since mem has not been updated yet.
        head_n = head_q;
        if (count_n != 2'd0) begin
            if (push && (wr_ptr == rd_ptr_n)) begin
                head_n = in_dat;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            head_q <= '0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
            end
            wr_ptr <= flush ? 1'b0 : (wr_ptr ^ push);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head_q <= head_n;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: derives N/Z/C/V, buffers results in a 2-entry FIFO, keeps STATUS.
// Latency: result pushed at edge k is valid on out_* after edge k.
// Backpressure: in_ready = (count < 2), independent of out_ready; flush empties the buffer.
//
// Ports: clk, rst_n (async active-low); upstream in_valid/in_ready/in_res/in_c/in_v/
// in_tag/in_flag_en; flush; downstream out_valid/out_ready/out_res/out_tag/out_flags;
// status = architectural {N,Z,C,V}, updated when a flag_en entry is retired.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_c,
    input  logic             in_v,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_flag_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [3:0]       status
);

    localparam int EW = entry_w(WIDTH, TAG_W);

    logic [FLAGS_W-1:0] in_flags;
    logic [EW-1:0]      in_entry;
    logic [EW-1:0]      out_entry;
    logic               out_flag_en;
    logic               retire;

    always_comb begin
        in_flags         = '0;
        in_flags[FLAG_N] = in_res[WIDTH-1];
        in_flags[FLAG_Z] = (in_res == '0);
        in_flags[FLAG_C] = in_c;
        in_flags[FLAG_V] = in_v;
    end

    assign in_entry = {in_res, in_tag, in_flags, in_flag_en};

    alu_skid_fifo #(
        .DW(EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_entry)
    );

    assign out_res     = out_entry[EW-1 -: WIDTH];
    assign out_tag     = out_entry[FLAGS_W+1 +: TAG_W];
    assign out_flags   = out_entry[1 +: FLAGS_W];
    assign out_flag_en = out_entry[0];

    // A pop in a flush cycle is discarded, so it must not retire flags.
    assign retire = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 4'd0;
        end else if (retire && out_flag_en) begin
            status <= out_flags;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_res = 16'h0;
    logic        in_c = 1'b0;
    logic        in_v = 1'b0;
    logic [2:0]  in_tag = 3'd0;
    logic        in_flag_en = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_res;
    logic [2:0]  out_tag;
    logic [3:0]  out_flags;
    logic [3:0]  status;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16), .TAG_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_c       (in_c),
        .in_v       (in_v),
        .in_tag     (in_tag),
        .in_flag_en (in_flag_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .status     (status)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] res;
        logic [2:0]  tag;
        logic [3:0]  flags;
        logic        fe;
    } ent_t;

    ent_t        q[$];
    ent_t        shown = '{16'h0, 3'd0, 4'd0, 1'b0};
    logic [3:0]  m_status = 4'd0;

    function automatic ent_t mk(input logic [15:0] r, input logic c, input logic v,
                                input logic [2:0] t, input logic fe);
        ent_t e;
        e.res   = r;
        e.tag   = t;
        e.flags = {r[15], (r == 16'h0), c, v};
        e.fe    = fe;
        return e;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        shown    = '{16'h0, 3'd0, 4'd0, 1'b0};
        m_status = 4'd0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                automatic bit can_push = (q.size() < 2) && in_valid;
                automatic ent_t ne = mk(in_res, in_c, in_v, in_tag, in_flag_en);
                if (q.size() > 0 && out_ready) begin
                    automatic ent_t e = q.pop_front();
                    if (e.fe) m_status = e.flags;
                end
                if (can_push) q.push_back(ne);
                if (q.size() > 0) shown = q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            chk("in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 2});
            chk("out_res",   {16'b0, out_res},   {16'b0, shown.res});
            chk("out_tag",   {29'b0, out_tag},   {29'b0, shown.tag});
            chk("out_flags", {28'b0, out_flags}, {28'b0, shown.flags});
            chk("status",    {28'b0, status},    {28'b0, m_status});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] r, input logic c, input logic v,
                         input logic [2:0] t, input logic fe);
        in_valid   = 1'b1;
        in_res     = r;
        in_c       = c;
        in_v       = v;
        in_tag     = t;
        in_flag_en = fe;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_res",   {16'b0, out_res},   32'd0);
        chk("rst_status",    {28'b0, status},    32'd0);
        #9 rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Zero result with flag_en: Z flag retired into STATUS.
        out_ready = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 3'd3, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_flags", {28'b0, out_flags}, 32'h4);
        chk("t1_tag",   {29'b0, out_tag},   32'd3);
        step();
        chk("t1_status", {28'b0, status}, 32'h4);

        // Negative result with C,V and flag_en=0: STATUS untouched.
        drive(16'h8001, 1'b1, 1'b1, 3'd5, 1'b0);
        step();
        in_valid = 1'b0;
        chk("t2_flags", {28'b0, out_flags}, 32'hB);
        step();
        chk("t2_status", {28'b0, status}, 32'h4);

        // Fill to full, hold a third input, then drain in order.
        out_ready = 1'b0;
        drive(16'h0011, 1'b0, 1'b0, 3'd1, 1'b0);
        step();
        drive(16'h0022, 1'b0, 1'b0, 3'd2, 1'b0);
        step();
        chk("t3_full", {31'b0, in_ready}, 32'd0);
        drive(16'h0033, 1'b0, 1'b0, 3'd3, 1'b0);
        step();
        step();
        chk("t3_head", {16'b0, out_res}, 32'h0011);
        out_ready = 1'b1;
        step();
        chk("t3_second", {16'b0, out_res}, 32'h0022);
        step();
        chk("t3_third", {16'b0, out_res}, 32'h0033);
        in_valid = 1'b0;
        step();
        chk("t3_empty", {31'b0, out_valid}, 32'd0);
        chk("t3_hold",  {16'b0, out_res},   32'h0033);

        // Streaming: push and pop every cycle.
        for (int i = 0; i < 6; i++) begin
            drive(16'h00AA + 16'(i), 1'b0, 1'b0, 3'(i), 1'b0);
            step();
            chk("t4_stream", {16'b0, out_res}, 32'h00AA + 32'(i));
            chk("t4_ready",  {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Flush with two entries buffered and a pop/push pending.
        out_ready = 1'b0;
        drive(16'h0101, 1'b0, 1'b0, 3'd1, 1'b1);
        step();
        drive(16'h0202, 1'b0, 1'b0, 3'd2, 1'b1);
        step();
        chk("t5_full", {31'b0, in_ready}, 32'd0);
        drive(16'h0303, 1'b0, 1'b0, 3'd3, 1'b1);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_valid",  {31'b0, out_valid}, 32'd0);
        chk("t5_ready",  {31'b0, in_ready},  32'd1);
        chk("t5_status", {28'b0, status},    32'h4);
        step();
        chk("t5_absent", {31'b0, out_valid}, 32'd0);

        // Flush at count=1 while a push is accepted-looking.
        out_ready = 1'b0;
        drive(16'h0404, 1'b0, 1'b0, 3'd4, 1'b1);
        step();
        drive(16'h0505, 1'b0, 1'b0, 3'd5, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t5b_absent", {31'b0, out_valid}, 32'd0);

        // Async reset mid-stream with two entries buffered.
        out_ready = 1'b1;
        drive(16'h8000, 1'b1, 1'b0, 3'd6, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("t6_status", {28'b0, status}, 32'hA);
        out_ready = 1'b0;
        drive(16'h1234, 1'b0, 1'b0, 3'd1, 1'b1);
        step();
        drive(16'h5678, 1'b0, 1'b0, 3'd2, 1'b1);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",  {31'b0, out_valid}, 32'd0);
        chk("t6_rst_res",    {16'b0, out_res},   32'd0);
        chk("t6_rst_tag",    {29'b0, out_tag},   32'd0);
        chk("t6_rst_flags",  {28'b0, out_flags}, 32'd0);
        chk("t6_rst_status", {28'b0, status},    32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_rel_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        drive(16'h0007, 1'b0, 1'b1, 3'd7, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t6_after", {16'b0, out_res}, 32'h0007);
        step();
        chk("t6_after_status", {28'b0, status}, 32'h1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
